// File: rtl/fpga_io_pkg.sv
// Shared board I/O package.
// Holds the serializer state encoding, the result word width used at
// instantiation, and the slow-clock half period of the key/slow-clock generator.
package fpga_io_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ALIGN = 2'd1,
      SHIFT = 2'd2,
      STOP  = 2'd3
   } ser_state_t;

   localparam int RESULT_W   = 8;
   localparam int CLK_R_HALF = 2500;

endpackage

// File: rtl/result_serializer_if.sv
// Bundle between the result producer / push source and the serial transmitter.
//   data_in, data_valid, push        : producer -> serializer
//   tx_data, tx_frame, busy, pending,
//   done                             : serializer -> GPIO / observer
// master = producer/observer side, slave = serializer side.
interface result_serializer_if #(
   parameter int DATA_W = 8
) ();

   logic [DATA_W-1:0] data_in;
   logic              data_valid;
   logic              push;
   logic              tx_data;
   logic              tx_frame;
   logic              busy;
   logic              pending;
   logic              done;

   modport master (
      output data_in, data_valid, push,
      input  tx_data, tx_frame, busy, pending, done
   );

   modport slave (
      input  data_in, data_valid, push,
      output tx_data, tx_frame, busy, pending, done
   );

endinterface

// File: rtl/result_serializer_edge_det.sv
// Generic edge detector: registers the previous level of a signal that is
// already synchronous to clk and reports rise/fall combinationally.
//   clk, rstn : clock, asynchronous active-low reset
//   clr       : synchronous clear, forces the stored level to RST_LVL
//   level     : sampled signal
//   rise/fall : one-cycle strobes while the new level differs from the stored one
module edge_det #(
   parameter logic RST_LVL = 1'b1
) (
   input  logic clk,
   input  logic rstn,
   input  logic clr,
   input  logic level,
   output logic rise,
   output logic fall
);

   logic level_d_reg;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         level_d_reg <= RST_LVL;
      end else if (clr) begin
         level_d_reg <= RST_LVL;
      end else begin
         level_d_reg <= level;
      end
   end

   assign rise = ~level_d_reg &  level;
   assign fall =  level_d_reg & ~level;

endmodule

// File: rtl/result_serializer.sv
// Serial result transmitter.
// Latches a result word, waits for a push pulse, then shifts the word out
// MSB-first on tx_data. Bits change one cycle after each falling edge of the
// slow clock clk_R so a receiver can sample on clk_R rising edges. tx_frame
// brackets the bits; after one further clk_R period with the frame low, done
// pulses for one cycle and busy drops.
//   clk   : system clock (also clocks the push and clk_R sources)
//   rstn  : asynchronous active-low reset
//   en    : block enable; low synchronously returns everything to reset state
//   clk_R : slow clock level, synchronous to clk
//   bus   : slave side of result_serializer_if
module result_serializer
   import fpga_io_pkg::*;
#(
   parameter int DATA_W = RESULT_W
) (
   input  logic                clk,
   input  logic                rstn,
   input  logic                en,
   input  logic                clk_R,
   result_serializer_if.slave  bus
);

   localparam int CNT_W = $clog2(DATA_W + 1);

   ser_state_t        state_reg,    state_next;
   logic [DATA_W-1:0] hold_reg,     hold_next;
   logic [DATA_W-1:0] shreg_reg,    shreg_next;
   logic [CNT_W-1:0]  cnt_reg,      cnt_next;
   logic              tx_data_reg,  tx_data_next;
   logic              tx_frame_reg, tx_frame_next;
   logic              busy_reg,     busy_next;
   logic              pending_reg,  pending_next;
   logic              done_reg,     done_next;

   logic              fall;
   logic              clk_r_rise_unused;

   // Previous clk_R level resets high, so a low level straight out of reset or
   // re-enable is seen as a falling edge, just as the generator would produce.
   edge_det #(
      .RST_LVL (1'b1)
   ) u_clk_r_edge (
      .clk   (clk),
      .rstn  (rstn),
      .clr   (~en),
      .level (clk_R),
      .rise  (clk_r_rise_unused),
      .fall  (fall)
   );

   always_comb begin
      state_next    = state_reg;
      hold_next     = hold_reg;
      shreg_next    = shreg_reg;
      cnt_next      = cnt_reg;
      tx_data_next  = tx_data_reg;
      tx_frame_next = tx_frame_reg;
      busy_next     = busy_reg;
      pending_next  = pending_reg;
      done_next     = 1'b0;

      case (state_reg)
         IDLE: begin
            // push without a waiting word is dropped; push while busy never
            // reaches here, so it cannot queue.
            if (bus.push && pending_reg) begin
               shreg_next   = hold_reg;
               pending_next = 1'b0;
               busy_next    = 1'b1;
               state_next   = ALIGN;
            end
         end
         ALIGN: begin
            if (fall) begin
               tx_data_next  = shreg_reg[DATA_W-1];
               tx_frame_next = 1'b1;
               shreg_next    = shreg_reg << 1;
               cnt_next      = CNT_W'(1);
               state_next    = SHIFT;
            end
         end
         SHIFT: begin
            if (fall) begin
               if (cnt_reg < CNT_W'(DATA_W)) begin
                  tx_data_next = shreg_reg[DATA_W-1];
                  shreg_next   = shreg_reg << 1;
                  cnt_next     = cnt_reg + CNT_W'(1);
               end else begin
                  tx_data_next  = 1'b0;
                  tx_frame_next = 1'b0;
                  cnt_next      = '0;
                  state_next    = STOP;
               end
            end
         end
         STOP: begin
            // Guard period: one full clk_R period with the frame low.
            if (fall) begin
               done_next  = 1'b1;
               busy_next  = 1'b0;
               state_next = IDLE;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase

      // Capture after the FSM so an accepted push in the same cycle takes the
      // old hold, while the new word is kept and stays pending.
      if (bus.data_valid) begin
         hold_next    = bus.data_in;
         pending_next = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_reg    <= IDLE;
         hold_reg     <= '0;
         shreg_reg    <= '0;
         cnt_reg      <= '0;
         tx_data_reg  <= 1'b0;
         tx_frame_reg <= 1'b0;
         busy_reg     <= 1'b0;
         pending_reg  <= 1'b0;
         done_reg     <= 1'b0;
      end else if (!en) begin
         state_reg    <= IDLE;
         hold_reg     <= '0;
         shreg_reg    <= '0;
         cnt_reg      <= '0;
         tx_data_reg  <= 1'b0;
         tx_frame_reg <= 1'b0;
         busy_reg     <= 1'b0;
         pending_reg  <= 1'b0;
         done_reg     <= 1'b0;
      end else begin
         state_reg    <= state_next;
         hold_reg     <= hold_next;
         shreg_reg    <= shreg_next;
         cnt_reg      <= cnt_next;
         tx_data_reg  <= tx_data_next;
         tx_frame_reg <= tx_frame_next;
         busy_reg     <= busy_next;
         pending_reg  <= pending_next;
         done_reg     <= done_next;
      end
   end

   assign bus.tx_data  = tx_data_reg;
   assign bus.tx_frame = tx_frame_reg;
   assign bus.busy     = busy_reg;
   assign bus.pending  = pending_reg;
   assign bus.done     = done_reg;

endmodule

// File: tb/tb_result_serializer.sv
// Self-checking bench for result_serializer.
// A local slow-clock generator (shortened half period) drives clk_R. Words
// accepted by a push are queued by a small model; a monitor rebuilds each
// frame from tx_data at clk_R rising edges and checks it against the queue,
// together with frame length and done delay/width.
module tb_result_serializer;
   import fpga_io_pkg::*;

   localparam int W    = RESULT_W;
   localparam int HALF = CLK_R_HALF / 125;   // 20 clk cycles
   localparam int PER  = 2 * HALF;

   logic clk   = 1'b0;
   logic rstn  = 1'b0;
   logic en    = 1'b0;
   logic clk_R = 1'b1;
   int   rcnt  = 0;

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (rcnt == HALF - 1) begin
         rcnt  <= 0;
         clk_R <= ~clk_R;
      end else begin
         rcnt <= rcnt + 1;
      end
   end

   result_serializer_if #(.DATA_W(W)) bus ();

   result_serializer #(.DATA_W(W)) dut (
      .clk   (clk),
      .rstn  (rstn),
      .en    (en),
      .clk_R (clk_R),
      .bus   (bus)
   );

   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // Model state
   logic [W-1:0] sb_q[$];
   logic [W-1:0] exp_hold    = '0;
   logic         exp_pending = 1'b0;
   logic         exp_busy    = 1'b0;
   bit           mon_skip    = 1'b0;

   // Monitor
   logic         prev_frame = 1'b0;
   logic         prev_clkr  = 1'b1;
   logic         prev_done  = 1'b0;
   int           fcnt = 0, dcnt = 0, nbits = 0, frames = 0, dones = 0;
   logic [W-1:0] rx_word = '0;
   logic [W-1:0] exp_word;

   always @(negedge clk) begin
      if (!prev_frame && bus.tx_frame) begin
         fcnt    = 1;
         nbits   = 0;
         rx_word = '0;
         frames++;
      end else if (bus.tx_frame) begin
         fcnt++;
      end
      if (bus.tx_frame && !prev_clkr && clk_R) begin
         rx_word = {rx_word[W-2:0], bus.tx_data};
         nbits++;
      end
      if (prev_frame && !bus.tx_frame) begin
         dcnt = 0;
         if (mon_skip) begin
            if (sb_q.size() != 0) exp_word = sb_q.pop_front();
         end else begin
            chk("frame_len", fcnt, W * PER);
            chk("bit_count", nbits, W);
            chk("tx_data_idle", bus.tx_data, 1'b0);
            if (sb_q.size() == 0) begin
               chk("sb_nonempty", 0, 1);
            end else begin
               exp_word = sb_q.pop_front();
               chk("frame_word", rx_word, exp_word);
               $display("[TB] frame received 0x%0h, expected 0x%0h", rx_word, exp_word);
            end
         end
      end else begin
         dcnt++;
      end
      if (prev_done) chk("done_width", bus.done, 1'b0);
      if (bus.done) begin
         dones++;
         if (!mon_skip) chk("done_delay", dcnt, PER);
         chk("busy_at_done", bus.busy, 1'b0);
      end
      prev_frame = bus.tx_frame;
      prev_clkr  = clk_R;
      prev_done  = bus.done;
   end

   // One stimulus cycle: optional capture and/or push, then check busy/pending.
   task automatic step(input bit dv, input logic [W-1:0] word, input bit psh);
      @(negedge clk);
      bus.data_valid = dv;
      bus.data_in    = word;
      bus.push       = psh;
      if (psh && !exp_busy && exp_pending) begin
         sb_q.push_back(exp_hold);
         exp_pending = 1'b0;
         exp_busy    = 1'b1;
      end
      if (dv) begin
         exp_hold    = word;
         exp_pending = 1'b1;
      end
      @(negedge clk);
      bus.data_valid = 1'b0;
      bus.push       = 1'b0;
      chk("busy", bus.busy, exp_busy);
      chk("pending", bus.pending, exp_pending);
      $display("[TB] step dv=%0b data=0x%0h push=%0b -> busy=%0b pending=%0b",
               dv, word, psh, bus.busy, bus.pending);
   endtask

   task automatic wait_done();
      int start;
      start = dones;
      for (int i = 0; i < (W + 4) * PER; i++) begin
         @(negedge clk);
         if (dones != start) break;
      end
      chk("done_seen", dones - start, 1);
      exp_busy = 1'b0;
      @(negedge clk);
      chk("busy_after", bus.busy, 1'b0);
      chk("pending_after", bus.pending, exp_pending);
   endtask

   task automatic wait_frame_rise();
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 2 * PER + 8; i++) begin
         @(negedge clk);
         if (bus.tx_frame) begin
            seen = 1'b1;
            break;
         end
      end
      chk("frame_start", seen, 1'b1);
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int f0, d0;
      bus.data_valid = 1'b0;
      bus.push       = 1'b0;
      bus.data_in    = '0;
      repeat (3) @(negedge clk);
      chk("rst_tx_data",  bus.tx_data,  1'b0);
      chk("rst_tx_frame", bus.tx_frame, 1'b0);
      chk("rst_busy",     bus.busy,     1'b0);
      chk("rst_pending",  bus.pending,  1'b0);
      chk("rst_done",     bus.done,     1'b0);
      rstn = 1'b1;
      en   = 1'b1;

      // Idle: no push, no activity
      repeat (3 * PER) @(negedge clk);
      chk("idle_frames", frames, 0);
      chk("idle_busy", bus.busy, 1'b0);

      // Basic frame
      step(1'b1, 8'hA5, 1'b0);
      step(1'b0, 8'h00, 1'b1);
      wait_done();

      // Push without data
      f0 = frames;
      step(1'b0, 8'h00, 1'b1);
      repeat (2 * PER) @(negedge clk);
      chk("nodata_frames", frames, f0);

      // Overwrite during frame, plus ignored pushes while busy
      step(1'b1, 8'h3C, 1'b0);
      step(1'b0, 8'h00, 1'b1);
      wait_frame_rise();
      repeat (3 * PER) @(negedge clk);
      step(1'b1, 8'hFF, 1'b1);
      repeat (PER / 2) @(negedge clk);
      step(1'b0, 8'h00, 1'b1);
      wait_done();
      step(1'b0, 8'h00, 1'b1);
      wait_done();

      // Capture and accepted push in the same cycle
      step(1'b1, 8'h11, 1'b0);
      step(1'b1, 8'h22, 1'b1);
      wait_done();
      step(1'b0, 8'h00, 1'b1);
      wait_done();

      // Enable abort during bit 3
      step(1'b1, 8'h5A, 1'b0);
      step(1'b0, 8'h00, 1'b1);
      wait_frame_rise();
      repeat (2 * PER + PER / 2) @(negedge clk);
      step(1'b1, 8'hC3, 1'b0);
      mon_skip = 1'b1;
      d0 = dones;
      @(negedge clk);
      en = 1'b0;
      @(negedge clk);
      chk("abort_tx_frame", bus.tx_frame, 1'b0);
      chk("abort_tx_data",  bus.tx_data,  1'b0);
      chk("abort_busy",     bus.busy,     1'b0);
      chk("abort_pending",  bus.pending,  1'b0);
      exp_busy    = 1'b0;
      exp_pending = 1'b0;
      exp_hold    = '0;
      en = 1'b1;
      repeat (2 * PER) @(negedge clk);
      chk("abort_no_done", dones, d0);
      mon_skip = 1'b0;
      f0 = frames;
      step(1'b0, 8'h00, 1'b1);
      repeat (2 * PER) @(negedge clk);
      chk("abort_no_resend", frames, f0);

      // Asynchronous reset mid-frame
      step(1'b1, 8'h77, 1'b0);
      step(1'b0, 8'h00, 1'b1);
      wait_frame_rise();
      repeat (PER) @(negedge clk);
      mon_skip = 1'b1;
      #2;
      rstn = 1'b0;
      #1;
      chk("arst_tx_frame", bus.tx_frame, 1'b0);
      chk("arst_tx_data",  bus.tx_data,  1'b0);
      chk("arst_busy",     bus.busy,     1'b0);
      chk("arst_pending",  bus.pending,  1'b0);
      chk("arst_done",     bus.done,     1'b0);
      exp_busy    = 1'b0;
      exp_pending = 1'b0;
      exp_hold    = '0;
      repeat (2) @(negedge clk);
      rstn = 1'b1;
      repeat (PER) @(negedge clk);
      mon_skip = 1'b0;

      chk("sb_drained", sb_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
